// File: rtl/board_io_bridge_pkg.sv
// rtl/board_io_bridge_pkg.sv - IO bus field map shared by the board IO bridge
package board_io_bridge_pkg;

   localparam int LED_LSB      = 0;
   localparam int LED_WIDTH    = 10;
   localparam int HEX0_LSB     = 10;
   localparam int HEX1_LSB     = 17;
   localparam int HEX2_LSB     = 24;
   localparam int HEX3_LSB     = 31;
   localparam int HEX4_LSB     = 38;
   localparam int HEX5_LSB     = 45;
   localparam int HEX_WIDTH    = 7;
   localparam int HEX_COUNT    = 6;

   localparam int SW_LSB       = 0;
   localparam int SW_WIDTH     = 10;
   localparam int KEY_LSB      = 10;
   localparam int KEY_WIDTH    = 4;
   localparam int IO_IN_WIDTH  = 14;
   localparam int IO_OUT_WIDTH = 52;

   // Segment fields on the bus are lit-high; the board pins are lit-low.
   function automatic logic [HEX_WIDTH-1:0] hex_pins(input logic [IO_OUT_WIDTH-1:0] bus,
                                                     input int idx);
      return ~bus[HEX0_LSB + idx*HEX_WIDTH +: HEX_WIDTH];
   endfunction

endpackage

// File: rtl/board_io_bridge_debounce_bit.sv
// rtl/board_io_bridge_debounce_bit.sv - two-flop synchronizer plus stability-count debouncer for one pin
module board_io_bridge_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic filtered
);

   localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_q;
   logic          sync_q;
   logic [CW-1:0] cnt;

   // Bring the asynchronous pin into the clock domain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
      end
   end

   // Accept a new level only after it has differed from the filtered value for DEBOUNCE_CYCLES clocks in a row.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         filtered <= 1'b0;
      end else if (sync_q == filtered) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         filtered <= sync_q;
         cnt      <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/board_io_bridge.sv
// rtl/board_io_bridge.sv - board pin bridge: debounced KEY/SW in, LED/HEX out (optional LED PWM: BOARD_IO_LED_PWM_EN)
module board_io_bridge
   import board_io_bridge_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PWM_WIDTH       = 8,
   parameter int LED_DUTY        = 128
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  key_raw,
   input  logic [9:0]  sw_raw,
   output logic [13:0] io_input_bus,
   input  logic [51:0] io_output_bus,
   output logic [9:0]  led,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5
);

   logic [IO_IN_WIDTH-1:0]  raw_vec;
   logic [IO_OUT_WIDTH-1:0] out_reg;
   logic [LED_WIDTH-1:0]    led_reg;

   // Keys are active-low on the board; flip them so pressed reads as 1 on the bus.
   assign raw_vec[KEY_LSB +: KEY_WIDTH] = ~key_raw;
   assign raw_vec[SW_LSB  +: SW_WIDTH]  = sw_raw;

   for (genvar i = 0; i < IO_IN_WIDTH; i++) begin : g_in
      board_io_bridge_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clock    (clock),
         .reset    (reset),
         .raw      (raw_vec[i]),
         .filtered (io_input_bus[i])
      );
   end

   // Capture the core's output bus so the pins change cleanly one clock later.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_reg <= '0;
      end else begin
         out_reg <= io_output_bus;
      end
   end

   assign led_reg = out_reg[LED_LSB +: LED_WIDTH];

   assign hex0 = hex_pins(out_reg, 0);
   assign hex1 = hex_pins(out_reg, 1);
   assign hex2 = hex_pins(out_reg, 2);
   assign hex3 = hex_pins(out_reg, 3);
   assign hex4 = hex_pins(out_reg, 4);
   assign hex5 = hex_pins(out_reg, 5);

`ifdef BOARD_IO_LED_PWM_EN
   logic [PWM_WIDTH-1:0] pwm_cnt;
   logic                 pwm_on;

   // Free-running brightness counter; wraps naturally at its width.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   assign pwm_on = (int'(pwm_cnt) < LED_DUTY);
   assign led    = led_reg & {LED_WIDTH{pwm_on}};
`else
   logic unused_pwm_cfg;

   assign unused_pwm_cfg = ^{PWM_WIDTH[0], LED_DUTY[0]};
   assign led            = led_reg;
`endif

endmodule

// File: tb/tb_board_io_bridge.sv
// tb/tb_board_io_bridge.sv - scoreboard bench for board_io_bridge against a stability-window model
module tb_board_io_bridge;

   localparam int DC = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  key_raw = 4'hF;
   logic [9:0]  sw_raw = '0;
   logic [51:0] io_output_bus = '0;
   logic [13:0] io_input_bus;
   logic [9:0]  led;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

   always #5 clock = ~clock;

   board_io_bridge #(
      .DEBOUNCE_CYCLES(DC),
      .PWM_WIDTH(4),
      .LED_DUTY(4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .key_raw       (key_raw),
      .sw_raw        (sw_raw),
      .io_input_bus  (io_input_bus),
      .io_output_bus (io_output_bus),
      .led           (led),
      .hex0          (hex0),
      .hex1          (hex1),
      .hex2          (hex2),
      .hex3          (hex3),
      .hex4          (hex4),
      .hex5          (hex5)
   );

   typedef struct packed {
      logic [13:0] in_bus;
      logic [9:0]  led;
      logic [41:0] hex_all;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model: sync_q is the pin level two clocks back; the filtered level flips
   // once the last DC sync_q samples all agree on the opposite level
   logic [13:0] m_rprev;
   logic [13:0] m_filt;
   logic [13:0] m_win[$];
   int          m_pwm;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_rprev = '0;
      m_filt  = '0;
      m_win.delete();
      m_pwm   = 0;
   endtask

   task automatic step(input logic [3:0] k, input logic [9:0] s, input logic [51:0] ob,
                       input logic rst_n);
      exp_t        e;
      logic [13:0] nf;
      logic        all_opp;
      @(negedge clock);
      key_raw       = k;
      sw_raw        = s;
      io_output_bus = ob;
      reset         = rst_n;
      if (!rst_n) begin
         model_reset();
         e.in_bus  = '0;
         e.led     = '0;
         e.hex_all = {42{1'b1}};
      end else begin
         nf = m_filt;
         if (m_win.size() == DC) begin
            for (int b = 0; b < 14; b++) begin
               all_opp = 1'b1;
               for (int j = 0; j < DC; j++)
                  if (m_win[j][b] == m_filt[b]) all_opp = 1'b0;
               if (all_opp) nf[b] = ~m_filt[b];
            end
         end
         m_filt = nf;
         m_win.push_front(m_rprev);
         if (m_win.size() > DC) void'(m_win.pop_back());
         m_rprev = {~k, s};
         e.in_bus = m_filt;
         e.led    = ob[9:0];
`ifdef BOARD_IO_LED_PWM_EN
         m_pwm = (m_pwm + 1) % 16;
         if (m_pwm >= 4) e.led = '0;
`endif
         for (int i = 0; i < 6; i++) e.hex_all[i*7 +: 7] = ~ob[10 + i*7 +: 7];
      end
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic [3:0] k, input logic [9:0] s, input logic [51:0] ob,
                      input logic rst_n);
      step(k, s, ob, rst_n);
      @(posedge clock);
      #2;
   endtask

   // monitor: every clock the DUT presents a new output word; pop and compare
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_in_bus", 64'(io_input_bus), 64'(e.in_bus));
            check("sb_led", 64'(led), 64'(e.led));
            check("sb_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(e.hex_all));
         end
      end
   end

   initial begin
      logic [3:0]  k;
      logic [9:0]  s;
      logic [51:0] ob;
      logic [13:0] flips;
      int          lit;
      model_reset();

      // reset with every key pressed and every switch on
      for (int i = 0; i < 3; i++) cyc(4'h0, 10'h3FF, '0, 1'b0);
      check("rst_in_bus", 64'(io_input_bus), 64'h0);
      check("rst_led", 64'(led), 64'h0);
      check("rst_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), {22'h0, {42{1'b1}}});
      for (int i = 1; i <= 6; i++) begin
         cyc(4'h0, 10'h3FF, '0, 1'b1);
         if (i == 5) check("rel_in_bus_early", 64'(io_input_bus), 64'h0);
         if (i == 6) check("rel_in_bus_6", 64'(io_input_bus), 64'h3FFF);
      end

      // switch edge and a too-short pulse
      for (int i = 0; i < 8; i++) cyc(4'hF, 10'h000, '0, 1'b1);
      check("idle_in_bus", 64'(io_input_bus), 64'h0);
      for (int i = 1; i <= 6; i++) begin
         cyc(4'hF, 10'h008, '0, 1'b1);
         if (i == 5) check("sw3_early", 64'(io_input_bus[3]), 64'h0);
         if (i == 6) check("sw3_rise", 64'(io_input_bus[3]), 64'h1);
      end
      for (int i = 0; i < 3; i++) cyc(4'hF, 10'h028, '0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cyc(4'hF, 10'h008, '0, 1'b1);
         if (io_input_bus[5] !== 1'b0) check("sw5_pulse", 64'(io_input_bus[5]), 64'h0);
      end
      check("sw5_pulse_end", 64'(io_input_bus[5]), 64'h0);

      // key press and release
      for (int i = 1; i <= 6; i++) begin
         cyc(4'hB, 10'h008, '0, 1'b1);
         if (i == 5) check("key2_early", 64'(io_input_bus[12]), 64'h0);
         if (i == 6) check("key2_press", 64'(io_input_bus[12]), 64'h1);
      end
      for (int i = 1; i <= 6; i++) begin
         cyc(4'hF, 10'h008, '0, 1'b1);
         if (i == 5) check("key2_hold", 64'(io_input_bus[12]), 64'h1);
         if (i == 6) check("key2_release", 64'(io_input_bus[12]), 64'h0);
      end

      // output unpack
      ob = '0;
      ob[9:0]   = 10'h2AA;
      ob[16:10] = 7'h3F;
      ob[51:45] = 7'h06;
      cyc(4'hF, 10'h000, ob, 1'b1);
`ifndef BOARD_IO_LED_PWM_EN
      check("unpack_led", 64'(led), 64'h2AA);
`endif
      check("unpack_hex0", 64'(hex0), 64'h40);
      check("unpack_hex5", 64'(hex5), 64'h79);
      check("unpack_hex1", 64'(hex1), 64'h7F);
      check("unpack_hex4", 64'(hex4), 64'h7F);

      // reset in the middle of a debounce count
      for (int i = 0; i < 8; i++) cyc(4'hF, 10'h000, '0, 1'b1);
      cyc(4'hF, 10'h001, '0, 1'b1);
      cyc(4'hF, 10'h001, '0, 1'b1);
      cyc(4'hF, 10'h001, '0, 1'b0);
      check("mid_rst_bit0", 64'(io_input_bus[0]), 64'h0);
      for (int i = 1; i <= 6; i++) begin
         cyc(4'hF, 10'h001, '0, 1'b1);
         if (i == 5) check("mid_rst_early", 64'(io_input_bus[0]), 64'h0);
         if (i == 6) check("mid_rst_rise", 64'(io_input_bus[0]), 64'h1);
      end

`ifdef BOARD_IO_LED_PWM_EN
      lit = 0;
      for (int i = 0; i < 32; i++) begin
         cyc(4'hF, 10'h001, 52'h3FF, 1'b1);
         if (led == 10'h3FF) lit++;
      end
      check("pwm_lit_count", 64'(lit), 64'd8);
`endif

      // randomized traffic with slow pin changes, glitches and occasional resets
      k = 4'hF;
      s = '0;
      for (int i = 0; i < 3000; i++) begin
         flips = '0;
         for (int b = 0; b < 14; b++) flips[b] = ($urandom_range(0, 11) == 0);
         {k, s} = {k, s} ^ flips;
         ob = {$urandom, $urandom};
         step(k, s, ob, ($urandom_range(0, 399) != 0));
      end

      repeat (3) @(posedge clock);
      #2;
      check("queue_drained", 64'(exp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
